// File: rtl/input_conditioner.sv
// input_conditioner: multi-channel input front end.
// A free-running prescaler produces a periodic sample tick. Each raw pin
// passes through an N-flop synchroniser. A tick-based debouncer then turns
// the synchronised pin into a registered stable level, and produces
// single-cycle rise/fall pulses in the same cycle that the level changes.
// The level register holds each channel's current accepted value. A channel
// accepts a new value only after DEBOUNCE_TICKS consecutive sample ticks have
// seen the synchronised input disagree with that level.

module input_conditioner #(
  parameter int CHANNELS       = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TICK_DIV       = 24000,
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [CHANNELS-1:0] async_in,
  output logic                tick,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  // Prescaler width has a floor of one bit so that TICK_DIV=1 still works.
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_TICKS + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_TICKS - 1);

  logic [PRE_W-1:0]    pre_cnt_r;
  logic                tick_r;
  logic [CHANNELS-1:0] sync_r [SYNC_STAGES];
  logic [CHANNELS-1:0] synced_s;

  logic [DB_W-1:0]     db_cnt_r [CHANNELS];
  logic [DB_W-1:0]     db_cnt_s [CHANNELS];
  logic [CHANNELS-1:0] level_r;
  logic [CHANNELS-1:0] level_s;
  logic [CHANNELS-1:0] rise_r;
  logic [CHANNELS-1:0] rise_s;
  logic [CHANNELS-1:0] fall_r;
  logic [CHANNELS-1:0] fall_s;

  assign synced_s = sync_r[SYNC_STAGES-1];

  // Prescaler: count enabled clocks and emit a one-cycle tick on wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_cnt_r <= {PRE_W{1'b0}};
      tick_r    <= 1'b0;
    end else if (enable) begin
      if (pre_cnt_r == PRE_LAST) begin
        pre_cnt_r <= {PRE_W{1'b0}};
        tick_r    <= 1'b1;
      end else begin
        pre_cnt_r <= pre_cnt_r + PRE_W'(1);
        tick_r    <= 1'b0;
      end
    end else begin
      pre_cnt_r <= pre_cnt_r;
      tick_r    <= 1'b0;
    end
  end

  // Synchroniser chain: runs every clock regardless of enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_r[k] <= {CHANNELS{1'b0}};
      end
    end else begin
      sync_r[0] <= async_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  // Debounce next-state: an agreeing input clears the count at once.
  // A disagreeing input advances the count only on ticks, and on the final
  // tick the new level is accepted together with its edge pulse.
  always_comb begin
    level_s = level_r;
    rise_s  = {CHANNELS{1'b0}};
    fall_s  = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      db_cnt_s[i] = db_cnt_r[i];
      if (synced_s[i] == level_r[i]) begin
        db_cnt_s[i] = {DB_W{1'b0}};
      end else if (tick_r) begin
        if (db_cnt_r[i] == DB_LAST) begin
          level_s[i]  = synced_s[i];
          rise_s[i]   = synced_s[i];
          fall_s[i]   = ~synced_s[i];
          db_cnt_s[i] = {DB_W{1'b0}};
        end else begin
          db_cnt_s[i] = db_cnt_r[i] + DB_W'(1);
        end
      end else begin
        db_cnt_s[i] = db_cnt_r[i];
      end
    end
  end

  // Debounce state and edge pulses: registered so that reset never pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      level_r <= {CHANNELS{1'b0}};
      rise_r  <= {CHANNELS{1'b0}};
      fall_r  <= {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
        db_cnt_r[i] <= {DB_W{1'b0}};
      end
    end else begin
      level_r <= level_s;
      rise_r  <= rise_s;
      fall_r  <= fall_s;
      for (int i = 0; i < CHANNELS; i++) begin
        db_cnt_r[i] <= db_cnt_s[i];
      end
    end
  end

  assign tick  = tick_r;
  assign level = level_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed scenarios plus a randomized phase.
// A cycle-level behavioural model checks tick, level, rise and fall on every
// clock. The model tracks enabled-edge counts, an input history queue for
// the synchroniser delay, and per-channel streaks of disagreeing ticks.

module tb_input_conditioner;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int TD = 4;
  localparam int DB = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [CH-1:0] async_in;
  logic          tick;
  logic [CH-1:0] level;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int            m_en_edges = 0;
  logic          m_tick = 1'b0;
  logic [CH-1:0] m_hist [SS];
  logic [CH-1:0] m_level = '0;
  logic [CH-1:0] m_rise = '0;
  logic [CH-1:0] m_fall = '0;
  int            m_streak [CH];

  logic [CH-1:0] seen_rise;
  logic [CH-1:0] seen_fall;

  input_conditioner #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .TICK_DIV(TD), .DEBOUNCE_TICKS(DB)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .async_in(async_in),
    .tick(tick), .level(level), .rise(rise), .fall(fall)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge,
  // then compare all outputs shortly after the edge.
  task automatic step();
    logic [CH-1:0] old_sync;
    logic          old_tick;
    @(posedge clk);
    old_sync = m_hist[SS-1];
    old_tick = m_tick;
    if (!reset) begin
      m_en_edges = 0;
      m_tick     = 1'b0;
      m_level    = '0;
      m_rise     = '0;
      m_fall     = '0;
      for (int k = 0; k < SS; k++) m_hist[k] = '0;
      for (int i = 0; i < CH; i++) m_streak[i] = 0;
    end else begin
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < CH; i++) begin
        if (old_sync[i] == m_level[i]) begin
          m_streak[i] = 0;
        end else if (old_tick) begin
          m_streak[i]++;
          if (m_streak[i] == DB) begin
            m_level[i]  = old_sync[i];
            m_rise[i]   = old_sync[i];
            m_fall[i]   = !old_sync[i];
            m_streak[i] = 0;
          end
        end
      end
      if (enable) begin
        m_en_edges++;
        m_tick = ((m_en_edges % TD) == 0);
      end else begin
        m_tick = 1'b0;
      end
      for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = async_in;
    end
    #1;
    check("tick", tick, m_tick);
    check("level", level, m_level);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
    seen_rise |= rise;
    seen_fall |= fall;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int lat;
    for (int k = 0; k < SS; k++) m_hist[k] = '0;
    for (int i = 0; i < CH; i++) m_streak[i] = 0;
    seen_rise = '0;
    seen_fall = '0;
    reset    = 1'b0;
    enable   = 1'b1;
    async_in = '0;

    // Reset, then release: tick on every 4th edge.
    run(3);
    check("rst_level", level, 0);
    check("rst_rise", rise, 0);
    check("rst_fall", fall, 0);
    reset = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      check("tick_sched", tick, ((n % TD) == 0) ? 1 : 0);
    end

    // ch0 rise held, then fall held.
    seen_rise = '0;
    seen_fall = '0;
    async_in[0] = 1'b1;
    run(20);
    check("ch0_level_hi", level, 4'b0001);
    check("ch0_rise_seen", seen_rise, 4'b0001);
    async_in[0] = 1'b0;
    run(20);
    check("ch0_level_lo", level, 0);
    check("ch0_fall_seen", seen_fall, 4'b0001);

    // ch1 short pulse: rejected.
    seen_rise = '0;
    seen_fall = '0;
    async_in[1] = 1'b1;
    run(6);
    async_in[1] = 1'b0;
    run(20);
    check("ch1_glitch_lvl", level[1], 0);
    check("ch1_glitch_edges", {seen_rise[1], seen_fall[1]}, 0);

    // ch2 bounce: high 8 clocks, low 3, then high held.
    async_in[2] = 1'b1;
    run(8);
    async_in[2] = 1'b0;
    run(3);
    check("ch2_bounce_lvl", level[2], 0);
    async_in[2] = 1'b1;
    run(20);
    check("ch2_final_lvl", level[2], 1);
    async_in[2] = 1'b0;
    run(20);

    // ch3 with enable dropped mid-debounce.
    async_in[3] = 1'b1;
    lat = 0;
    for (int n = 0; n < 40 && lat == 0; n++) begin
      step();
      if (m_streak[3] == 2) lat = 1;
    end
    check("ch3_reach_cnt2", lat, 1);
    enable = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step();
      check("ch3_hold_tick", tick, 0);
      check("ch3_hold_lvl", level[3], 0);
    end
    enable = 1'b1;
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      step();
      if (level[3] && lat == 0) lat = n;
    end
    check("ch3_resume_ok", (lat >= 1 && lat <= TD + 1) ? 1 : 0, 1);
    async_in[3] = 1'b0;
    run(20);

    // Reset mid-debounce on ch0 discards progress.
    async_in[0] = 1'b1;
    lat = 0;
    for (int n = 0; n < 40 && lat == 0; n++) begin
      step();
      if (m_streak[0] == 2) lat = 1;
    end
    check("ch0_reach_cnt2", lat, 1);
    reset = 1'b0;
    step();
    check("midrst_tick", tick, 0);
    check("midrst_level", level, 0);
    check("midrst_edges", {rise, fall}, 0);
    reset = 1'b1;
    lat = 0;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (rise[0] && lat == 0) lat = n;
    end
    check("midrst_rise_lat", lat, 13);

    // Randomized phase.
    for (int n = 0; n < 1500; n++) begin
      reset  = ($urandom_range(0, 599) != 0);
      enable = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 11) == 0) async_in[i] = ~async_in[i];
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
